slice_add_sequencer: RTL and testbench
======================================

Name: slice_add_sequencer

Overview:
- Multi-cycle add/subtract engine that time-multiplexes a single 16-bit carry-lookahead adder slice over WIDTH-bit operands, one slice per cycle, LSB slice first.
- Sits between an issuing unit (valid/ready request side) and a consumer (valid/ready result side).
- Replaces a full-width adder where area matters more than latency.
- Carry is registered between slices, so the critical path stays that of one 16-bit slice.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 16, minimum 16.
- NSLICE, WIDTH/16, derived slice count; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  engine can accept a request.
- op_a  input  WIDTH  operand A, sampled on request handshake.
- op_b  input  WIDTH  operand B, sampled on request handshake.
- sub  input  1  1 = A-B, 0 = A+B, sampled on request handshake.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  A+B or A-B, modulo 2^WIDTH.
- carry_out  output  1  carry out of MSB (for sub: 1 = no borrow, A>=B unsigned).
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, slice index=0, carry register=0.
  - in_ready=1, out_valid=0, result=0, carry_out=0, overflow=0.
- States: IDLE, RUN, DONE.
- in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE:
  - On in_valid&in_ready in cycle T: register op_a, ~op_b if sub else op_b, and sub.
  - Initialize carry register to sub (0 for add, 1 for sub); idx=0; go to RUN.
  - in_valid without handshake has no effect.
- RUN:
  - Each cycle: slice adder computes A[idx*16+:16] + Bx[idx*16+:16] + carry.
  - The 16-bit sum is written to result[idx*16+:16]; the slice carry is written to the carry register; idx increments.
  - The final slice (idx=NSLICE-1) also does the following:
    - carry_out = slice carry.
    - overflow = (A[MSB]==Bx[MSB]) && (sum[MSB]!=A[MSB]), where Bx is the possibly-inverted B.
    - Transition to DONE.
  - RUN lasts exactly NSLICE cycles: T+1..T+NSLICE.
- DONE:
  - out_valid=1 from cycle T+NSLICE+1.
  - result, carry_out and overflow are held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: go to IDLE (in_ready=1 next cycle).
  - result, carry_out and overflow keep their values in IDLE until the next RUN overwrites them.
- Latency:
  - Request handshake to out_valid = NSLICE+1 cycles.
  - Minimum handshake-to-handshake issue interval = NSLICE+2 cycles (no accept in the DONE-exit cycle).
- Input changes outside the request handshake are ignored; operands are never re-sampled mid-operation.
- out_ready outside DONE is ignored.
- Wrap-around: result is modulo 2^WIDTH; carry beyond the MSB appears only on carry_out.
- Reset mid-RUN or mid-DONE: the operation is aborted, nothing is delivered, and all outputs take their reset values.
- WIDTH=16: RUN is a single cycle and latency is 2.

Test Plan:
- WIDTH=32, add 0x0000FFFF + 0x00000001 -> result 0x00010000, carry_out 0, overflow 0. Checks the inter-slice carry; out_valid exactly 3 cycles after the handshake.
- Add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, carry_out 1, overflow 0. Checks the full carry ripple.
- Sub 0x00000000 - 0x00000001 -> result 0xFFFFFFFF, carry_out 0 (borrow), overflow 0.
- Signed overflow cases:
  - 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1.
  - Sub 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, overflow 1, carry_out 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - result is stable, in_ready=0, and in_valid pulses are ignored.
  - On release: in_ready=1 the cycle after the result handshake; a second request 0x12345678+0x11111111 then yields 0x23456789.
- Assert rst during RUN cycle 1 of 0xFFFF0000+0x00010000, then release -> out_valid=0, in_ready=1, result=0.
  - A following request 0x00000002+0x00000003 yields 0x00000005 with no leftover carry.

Source files
------------

// File: rtl/slice_add_sequencer.sv
// slice_add_sequencer: WIDTH-bit add/subtract, one 16-bit CLA slice per cycle, LSB first.
// Revision: 1.0
`default_nettype none

module slice_add_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / 16;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IDXW-1:0]  idx;
  logic [IDXW+3:0]  base;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] bx_reg;
  logic             carry_reg;

  logic [15:0] a_s, b_s, s_s;
  logic [15:0] g, p, bc;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;
  logic        c_s;

  assign base      = {idx, 4'b0000};
  assign a_s       = a_reg[base +: 16];
  assign b_s       = bx_reg[base +: 16];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Two-level lookahead: 4-bit groups, group carries resolved from group G/P.
  always_comb begin
    g  = a_s & b_s;
    p  = a_s ^ b_s;
    gg = '0;
    gp = '0;
    gc = '0;
    bc = '0;
    gc[0] = carry_reg;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int i = 0; i < 16; i++) begin
      if ((i % 4) == 0) bc[i] = gc[i/4];
      else              bc[i] = g[i-1] | (p[i-1] & bc[i-1]);
    end
    s_s = p ^ bc;
    c_s = gc[4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      bx_reg    <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            bx_reg    <= sub ? ~op_b : op_b;
            carry_reg <= sub;  // +1 completes the two's complement of B
            idx       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          result[base +: 16] <= s_s;
          carry_reg          <= c_s;
          if (idx == LAST) begin
            carry_out <= c_s;
            overflow  <= (a_s[15] == b_s[15]) && (s_s[15] != a_s[15]);
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_slice_add_sequencer.sv
// tb_slice_add_sequencer: directed vectors for slice_add_sequencer at WIDTH=32.
// Revision: 1.0
`default_nettype none

module tb_slice_add_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  slice_add_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, then count edges from the accepting edge until out_valid.
  task automatic issue_and_wait(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic s);
    int n;
    check_value({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    sub      = s;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        in_valid = 1'b0;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'hCAFE_F00D;
        sub      = ~s;
      end
    end while (!out_valid && n < 20);
    check_value({tag, " latency"}, n, 32'd3);
  endtask

  task automatic check_result(input string tag, input logic [31:0] r, input logic c,
                              input logic v);
    check_value({tag, " result"}, result, r);
    check_value({tag, " carry_out"}, {31'd0, carry_out}, {31'd0, c});
    check_value({tag, " overflow"}, {31'd0, overflow}, {31'd0, v});
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_value({tag, " out_valid after accept"}, {31'd0, out_valid}, 32'd0);
    check_value({tag, " in_ready after accept"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] r, input logic c, input logic v);
    issue_and_wait(tag, a, b, s);
    check_result(tag, r, c, v);
    accept(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    tick();
    tick();
    check_value("reset in_ready", {31'd0, in_ready}, 32'd1);
    check_value("reset out_valid", {31'd0, out_valid}, 32'd0);
    check_result("reset", 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    run_op("add slice carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    run_op("add full ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("sub borrow",      32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("add signed ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("sub signed ovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_op("sub no borrow",   32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0);

    // Backpressure: result held, in_valid pulses ignored while DONE.
    issue_and_wait("bp", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      op_a     = 32'h1111_1111 * (i + 1);
      op_b     = 32'h0F0F_0F0F;
      tick();
      check_value("bp held result", result, 32'hFFFF_FFFF);
      check_value("bp in_ready low", {31'd0, in_ready}, 32'd0);
      check_value("bp out_valid high", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    check_result("bp", 32'hFFFF_FFFF, 1'b0, 1'b0);
    accept("bp");
    check_value("bp idle keeps result", result, 32'hFFFF_FFFF);
    run_op("second req", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    // Reset during the first RUN cycle aborts the operation.
    in_valid = 1'b1;
    op_a     = 32'hFFFF_0000;
    op_b     = 32'h0001_0000;
    sub      = 1'b0;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_value("abort out_valid", {31'd0, out_valid}, 32'd0);
    check_value("abort in_ready", {31'd0, in_ready}, 32'd1);
    check_result("abort", 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check_value("post-abort out_valid", {31'd0, out_valid}, 32'd0);
    check_value("post-abort result", result, 32'h0);
    run_op("post-abort add", 32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
